csr_loader: RTL

//  Upstream stage of the CSR SpMV engine. Takes a dense N_ROWS x N_COLS matrix as a row-major stream,

---
 rtl/csr_loader.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/csr_loader.sv
// Dense-to-CSR loader: consumes a row-major N_ROWS x N_COLS stream, drops zeros and
// writes S values, column indices and row pointers into the SpMV engine RAMs.
//
// state  | meaning
// IDLE   | waiting for start after reset; no writes
// INIT   | one cycle; rp[0]=0 is on the row-pointer port
// STREAM | accepting elements; one beat per cycle when in_valid is high
// DONE   | image complete, done held high until the next start
module csr_loader #(
    parameter int N_ROWS  = 16,
    parameter int N_COLS  = 16,
    parameter int DATA_W  = 8,
    parameter int NNZ_MAX = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              s_we,
    output logic [5:0]        s_addr,
    output logic [DATA_W-1:0] s_data,
    output logic [3:0]        col_data,
    output logic              rp_we,
    output logic [5:0]        rp_addr,
    output logic [6:0]        rp_data,
    output logic [6:0]        nnz_count,
    output logic              overflow,
    output logic              done,
    output logic [11:0]       clock_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INIT   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] COL_LAST = 4'(N_COLS - 1);
    localparam logic [3:0] ROW_LAST = 4'(N_ROWS - 1);
    localparam logic [6:0] NNZ_LIM  = 7'(NNZ_MAX);

    state_t              state_q, state_d;
    logic [3:0]          row_q, row_d;
    logic [3:0]          col_q, col_d;
    logic [6:0]          nnz_q, nnz_d;
    logic                overflow_q, overflow_d;
    logic                done_q, done_d;
    logic [11:0]         clk_cnt_q, clk_cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                s_we_q, s_we_d;
    logic [5:0]          s_addr_q, s_addr_d;
    logic [DATA_W-1:0]   s_data_q, s_data_d;
    logic [3:0]          col_data_q, col_data_d;
    logic                rp_we_q, rp_we_d;
    logic [5:0]          rp_addr_q, rp_addr_d;
    logic [6:0]          rp_data_q, rp_data_d;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        nnz_d      = nnz_q;
        overflow_d = overflow_q;
        done_d     = done_q;
        clk_cnt_d  = clk_cnt_q;
        in_ready_d = in_ready_q;
        s_we_d     = 1'b0;
        s_addr_d   = s_addr_q;
        s_data_d   = s_data_q;
        col_data_d = col_data_q;
        rp_we_d    = 1'b0;
        rp_addr_d  = rp_addr_q;
        rp_data_d  = rp_data_q;

        case (state_q)
            ST_INIT: begin
                state_d    = ST_STREAM;
                in_ready_d = 1'b1;
                if (clk_cnt_q != 12'hFFF) clk_cnt_d = clk_cnt_q + 12'd1;
            end
            ST_STREAM: begin
                if (clk_cnt_q != 12'hFFF) clk_cnt_d = clk_cnt_q + 12'd1;
                if (in_valid) begin
                    if (in_data != '0) begin
                        if (nnz_q < NNZ_LIM) begin
                            s_we_d     = 1'b1;
                            s_addr_d   = nnz_q[5:0];
                            s_data_d   = in_data;
                            col_data_d = col_q;
                            nnz_d      = nnz_q + 7'd1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                    if (col_q == COL_LAST) begin
                        // rp_data uses nnz_d so a write on the last column is included
                        rp_we_d   = 1'b1;
                        rp_addr_d = {2'b00, row_q} + 6'd1;
                        rp_data_d = nnz_d;
                        col_d     = 4'd0;
                        row_d     = row_q + 4'd1;
                        if (row_q == ROW_LAST) begin
                            state_d    = ST_DONE;
                            in_ready_d = 1'b0;
                        end
                    end else begin
                        col_d = col_q + 4'd1;
                    end
                end
            end
            ST_DONE: done_d = 1'b1;
            default: ;
        endcase

        if ((state_q == ST_IDLE || state_q == ST_DONE) && start) begin
            state_d    = ST_INIT;
            row_d      = 4'd0;
            col_d      = 4'd0;
            nnz_d      = 7'd0;
            overflow_d = 1'b0;
            done_d     = 1'b0;
            clk_cnt_d  = 12'd0;
            rp_we_d    = 1'b1;
            rp_addr_d  = 6'd0;
            rp_data_d  = 7'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            nnz_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            clk_cnt_q  <= '0;
            in_ready_q <= 1'b0;
            s_we_q     <= 1'b0;
            s_addr_q   <= '0;
            s_data_q   <= '0;
            col_data_q <= '0;
            rp_we_q    <= 1'b0;
            rp_addr_q  <= '0;
            rp_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            nnz_q      <= nnz_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            clk_cnt_q  <= clk_cnt_d;
            in_ready_q <= in_ready_d;
            s_we_q     <= s_we_d;
            s_addr_q   <= s_addr_d;
            s_data_q   <= s_data_d;
            col_data_q <= col_data_d;
            rp_we_q    <= rp_we_d;
            rp_addr_q  <= rp_addr_d;
            rp_data_q  <= rp_data_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign s_we        = s_we_q;
    assign s_addr      = s_addr_q;
    assign s_data      = s_data_q;
    assign col_data    = col_data_q;
    assign rp_we       = rp_we_q;
    assign rp_addr     = rp_addr_q;
    assign rp_data     = rp_data_q;
    assign nnz_count   = nnz_q;
    assign overflow    = overflow_q;
    assign done        = done_q;
    assign clock_count = clk_cnt_q;

endmodule
